multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle RISC-V control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and adds load/store with memory ready handshakes. It resolves all six branch conditions internally on XLEN-wide operands and adds illegal-opcode and memory-timeout traps. It sits between the instruction register and the datapath muxes, register file, ALU and PC.

---
 rtl/multicycle_control_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// resolves branches on register operands and traps on illegal opcodes
// or memory waits that exceed WAIT_LIMIT.
module multicycle_control_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            ir_write,
    output logic            dmem_req,
    output logic            memwrite,
    output logic            mem2reg,
    output logic            wb_pc4,
    output logic            alusrc,
    output logic [3:0]      aluctl,
    output logic            regwrite,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            retired,
    output logic            illegal,
    output logic            timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic             timeout_q;

    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic       legal_c;
    logic       alu_src_c;
    logic [3:0] alu_op_c;
    logic       lt_s_c, lt_u_c, taken_c;
    logic       waiting_c;
    logic       wait_expired_c;

    // Only funct7[5] distinguishes anything here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Instruction class decode and ALU control.
    always_comb begin
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_I);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_lui    = (opcode == OP_LUI);

        // Branch funct3 010/011 has no defined condition.
        legal_c = is_r | is_i | is_load | is_store | is_jal | is_jalr | is_lui |
                  (is_branch & (funct3[2:1] != 2'b01));

        alu_src_c = is_i | is_load | is_store | is_jalr | is_lui;

        alu_op_c = ALU_ADD;
        if (is_branch) begin
            alu_op_c = ALU_SUB;
        end else if (is_r || is_i) begin
            case (funct3)
                3'b111:  alu_op_c = ALU_AND;
                3'b110:  alu_op_c = ALU_OR;
                3'b000:  if (is_r && funct7[5]) alu_op_c = ALU_SUB;
                default: alu_op_c = ALU_ADD;
            endcase
        end
    end

    // Branch condition on the full-width operands.
    always_comb begin
        lt_s_c = $signed(rs1_data) < $signed(rs2_data);
        lt_u_c = rs1_data < rs2_data;
        case (funct3)
            3'b000:  taken_c = (rs1_data == rs2_data);
            3'b001:  taken_c = (rs1_data != rs2_data);
            3'b100:  taken_c = lt_s_c;
            3'b101:  taken_c = !lt_s_c;
            3'b110:  taken_c = lt_u_c;
            3'b111:  taken_c = !lt_u_c;
            default: taken_c = 1'b0;
        endcase
    end

    // Memory wait tracking; ready on the limit cycle still completes.
    always_comb begin
        waiting_c      = ((state == S_FETCH) && !imem_ready) ||
                         ((state == S_MEM) && !dmem_ready);
        wait_expired_c = waiting_c && (wait_cnt == CNT_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (imem_ready)          state_next = S_DECODE;
                else if (wait_expired_c) state_next = S_TRAP;
            end
            S_DECODE: begin
                state_next = legal_c ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_load || is_store) state_next = S_MEM;
                else if (is_branch)      state_next = S_FETCH;
                else                     state_next = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)          state_next = is_load ? S_WB : S_FETCH;
                else if (wait_expired_c) state_next = S_TRAP;
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Wait counter restarts on every state change; trap flags are sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting_c) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((state == S_DECODE) && !legal_c) begin
                illegal_q <= 1'b1;
            end
            if (wait_expired_c) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Output decode; the ALU keeps the instruction's operation through
    // MEM and WB because its result is not latched.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        memwrite = 1'b0;
        mem2reg  = 1'b0;
        wb_pc4   = 1'b0;
        alusrc   = 1'b0;
        aluctl   = 4'b0000;
        regwrite = 1'b0;
        pc_write = 1'b0;
        pc_src   = PC_PLUS4;
        retired  = 1'b0;
        illegal  = 1'b0;
        timeout  = 1'b0;
        if (!reset) begin
            illegal = illegal_q;
            timeout = timeout_q;
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_EXEC: begin
                    alusrc = alu_src_c;
                    aluctl = alu_op_c;
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = taken_c ? PC_REL : PC_PLUS4;
                        retired  = 1'b1;
                    end
                end
                S_MEM: begin
                    alusrc   = alu_src_c;
                    aluctl   = alu_op_c;
                    dmem_req = 1'b1;
                    memwrite = is_store;
                    if (dmem_ready && is_store) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                    end
                end
                S_WB: begin
                    alusrc   = alu_src_c;
                    aluctl   = alu_op_c;
                    regwrite = 1'b1;
                    pc_write = 1'b1;
                    retired  = 1'b1;
                    mem2reg  = is_load;
                    wb_pc4   = is_jal | is_jalr;
                    if (is_jal)       pc_src = PC_REL;
                    else if (is_jalr) pc_src = PC_REG;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: table of single instructions
// plus hand sequences for memory waits, timeout, illegal trap and reset.
module tb_multicycle_control_unit;

    logic        clk, reset;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        imem_ready, dmem_ready;
    logic        imem_req, ir_write, dmem_req, memwrite, mem2reg, wb_pc4, alusrc;
    logic [3:0]  aluctl;
    logic        regwrite, pc_write, retired, illegal, timeout;
    logic [1:0]  pc_src;
    logic [17:0] all_outs;

    int n_err = 0;
    int n_checks = 0;

    multicycle_control_unit #(.XLEN(32), .WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .dmem_req(dmem_req), .memwrite(memwrite), .mem2reg(mem2reg), .wb_pc4(wb_pc4),
        .alusrc(alusrc), .aluctl(aluctl), .regwrite(regwrite), .pc_write(pc_write),
        .pc_src(pc_src), .retired(retired), .illegal(illegal), .timeout(timeout)
    );

    assign all_outs = {imem_req, ir_write, dmem_req, memwrite, mem2reg, wb_pc4, alusrc,
                       aluctl, regwrite, pc_write, pc_src, retired, illegal, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [3:0]  aluctl;
        logic        alusrc;
        logic [1:0]  pc_src;
        int          n_rw;
        logic        m2r;
        logic        pc4;
        logic        mw;
    } vec_t;

    typedef struct {
        int         lat;
        int         n_dreq;
        int         n_rw;
        int         n_irw;
        logic       mw;
        logic [3:0] ex_aluctl;
        logic       ex_alusrc;
        logic [1:0] pc_src;
        logic       m2r;
        logic       pc4;
        logic       pcw;
    } res_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    res_t r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH; starts and ends just after a rising edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] a, input logic [31:0] b, input int i_wait,
                             input int d_wait, input int max_cyc, output res_t res);
        int mem_seen;
        bit done;
        res.lat = 0; res.n_dreq = 0; res.n_rw = 0; res.n_irw = 0; res.mw = 1'b0;
        res.ex_aluctl = 4'hx; res.ex_alusrc = 1'bx; res.pc_src = 2'bx;
        res.m2r = 1'bx; res.pc4 = 1'bx; res.pcw = 1'b0;
        mem_seen = 0;
        done = 1'b0;
        for (int c = 1; c <= max_cyc && !done; c++) begin
            opcode = op; funct3 = f3; funct7 = f7; rs1_data = a; rs2_data = b;
            imem_ready = (c > i_wait);
            dmem_ready = dmem_req && (mem_seen >= d_wait);
            if (dmem_req) mem_seen++;
            @(negedge clk);
            if (c == 3 + i_wait) begin
                res.ex_aluctl = aluctl;
                res.ex_alusrc = alusrc;
            end
            if (ir_write) res.n_irw++;
            if (dmem_req) res.n_dreq++;
            if (regwrite) res.n_rw++;
            if (memwrite) res.mw = 1'b1;
            if (retired) begin
                res.lat = c; res.pc_src = pc_src; res.m2r = mem2reg;
                res.pc4 = wb_pc4; res.pcw = pc_write;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, " outputs in reset"}, 32'(all_outs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check({tag, " imem_req after release"}, 32'(imem_req), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //         op       f3      f7     a             b       lat alu     src   pcs    rw m2r  pc4   mw
        vecs[0]  = '{OP_R,   3'b000, 7'h00, 32'd0,        32'd0,  4, 4'b0010, 1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_R,   3'b000, 7'h20, 32'd0,        32'd0,  4, 4'b0110, 1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_R,   3'b111, 7'h00, 32'd0,        32'd0,  4, 4'b0000, 1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_I,   3'b110, 7'h00, 32'd0,        32'd0,  4, 4'b0001, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_I,   3'b000, 7'h20, 32'd0,        32'd0,  4, 4'b0010, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_LUI, 3'b000, 7'h00, 32'd0,        32'd0,  4, 4'b0010, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_JAL, 3'b000, 7'h00, 32'd0,        32'd0,  4, 4'b0010, 1'b0, 2'b01, 1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{OP_JALR,3'b000, 7'h00, 32'd0,        32'd0,  4, 4'b0010, 1'b1, 2'b10, 1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{OP_BR,  3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,  3, 4'b0110, 1'b0, 2'b01, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_BR,  3'b110, 7'h00, 32'hFFFFFFFF, 32'd1,  3, 4'b0110, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_BR,  3'b000, 7'h00, 32'd5,        32'd5,  3, 4'b0110, 1'b0, 2'b01, 0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_BR,  3'b111, 7'h00, 32'd0,        32'd0,  3, 4'b0110, 1'b0, 2'b01, 0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_BR,  3'b001, 7'h00, 32'd5,        32'd5,  3, 4'b0110, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_BR,  3'b101, 7'h00, 32'hFFFFFFFF, 32'd1,  3, 4'b0110, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_ST,  3'b010, 7'h00, 32'd0,        32'd0,  4, 4'b0010, 1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{OP_LD,  3'b010, 7'h00, 32'd0,        32'd0,  5, 4'b0010, 1'b1, 2'b00, 1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{OP_R,   3'b100, 7'h20, 32'd0,        32'd0,  4, 4'b0010, 1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("outputs held in reset", 32'(all_outs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("imem_req after first release", 32'(imem_req), 32'h1);

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, 0, 0, 12, r);
            check($sformatf("v%0d latency", i), r.lat, vecs[i].lat);
            check($sformatf("v%0d exec aluctl", i), 32'(r.ex_aluctl), 32'(vecs[i].aluctl));
            check($sformatf("v%0d exec alusrc", i), 32'(r.ex_alusrc), 32'(vecs[i].alusrc));
            check($sformatf("v%0d pc_src", i), 32'(r.pc_src), 32'(vecs[i].pc_src));
            check($sformatf("v%0d pc_write", i), 32'(r.pcw), 32'h1);
            check($sformatf("v%0d regwrite cycles", i), r.n_rw, vecs[i].n_rw);
            check($sformatf("v%0d mem2reg", i), 32'(r.m2r), 32'(vecs[i].m2r));
            check($sformatf("v%0d wb_pc4", i), 32'(r.pc4), 32'(vecs[i].pc4));
            check($sformatf("v%0d memwrite", i), 32'(r.mw), 32'(vecs[i].mw));
            check($sformatf("v%0d ir_write cycles", i), r.n_irw, 1);
        end

        // Fetch stalled for two cycles.
        run_instr(OP_R, 3'b000, 7'h00, 32'd0, 32'd0, 2, 0, 12, r);
        check("add imem wait latency", r.lat, 6);
        check("add imem wait ir_write", r.n_irw, 1);
        check("add imem wait aluctl", 32'(r.ex_aluctl), 32'h2);

        // Load with three data wait cycles.
        run_instr(OP_LD, 3'b010, 7'h00, 32'd0, 32'd0, 0, 3, 16, r);
        check("lw wait latency", r.lat, 8);
        check("lw wait dmem_req cycles", r.n_dreq, 4);
        check("lw wait memwrite", 32'(r.mw), 32'h0);
        check("lw wait mem2reg", 32'(r.m2r), 32'h1);
        check("lw wait regwrite", r.n_rw, 1);

        // Store: ready arrives on the limit cycle and still completes.
        run_instr(OP_ST, 3'b010, 7'h00, 32'd0, 32'd0, 0, 15, 26, r);
        check("sw limit latency", r.lat, 19);
        check("sw limit dmem_req cycles", r.n_dreq, 16);
        check("sw limit timeout", 32'(timeout), 32'h0);

        // Store: one more wait cycle traps.
        run_instr(OP_ST, 3'b010, 7'h00, 32'd0, 32'd0, 0, 16, 22, r);
        check("sw timeout no retire", r.lat, 0);
        check("sw timeout dmem_req cycles", r.n_dreq, 16);
        check("sw timeout trap outputs", 32'(all_outs), 32'h1);
        pulse_reset("after timeout");

        // Illegal opcode.
        run_instr(7'b1111111, 3'b000, 7'h00, 32'd0, 32'd0, 0, 0, 6, r);
        check("illegal no retire", r.lat, 0);
        check("illegal trap outputs", 32'(all_outs), 32'h2);
        pulse_reset("after illegal");

        // Branch with undefined funct3.
        run_instr(OP_BR, 3'b010, 7'h00, 32'd1, 32'd1, 0, 0, 5, r);
        check("bad branch no retire", r.lat, 0);
        check("bad branch trap outputs", 32'(all_outs), 32'h2);
        pulse_reset("after bad branch");

        // Reset mid-instruction, then a clean instruction.
        run_instr(OP_R, 3'b000, 7'h00, 32'd0, 32'd0, 0, 0, 3, r);
        check("partial add no regwrite", r.n_rw, 0);
        pulse_reset("mid instruction");
        run_instr(OP_R, 3'b000, 7'h00, 32'd0, 32'd0, 0, 0, 12, r);
        check("add after reset latency", r.lat, 4);
        check("add after reset regwrite", r.n_rw, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
